// File: rtl/icache_pkg.sv
// Shared refill/forward definitions: FSM encoding and default geometry.
package icache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_WAIT = 2'd2
  } fill_state_e;

  localparam int DEF_ADDR_W     = 18;
  localparam int DEF_WORD_W     = 32;
  localparam int DEF_LINE_WORDS = 4;

endpackage

// File: rtl/refill_line_buf.sv
// One-line refill buffer: LINE_WORDS data slots plus a per-slot valid mask.
module refill_line_buf
  import icache_pkg::*;
#(
  parameter int WORD_W     = DEF_WORD_W,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int OFFS_W     = $clog2(LINE_WORDS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_clr,
  input  logic                  i_wr_en,
  input  logic [OFFS_W-1:0]     i_wr_idx,
  input  logic [WORD_W-1:0]     i_wr_data,
  input  logic [OFFS_W-1:0]     i_rd_idx,
  output logic [WORD_W-1:0]     o_rd_data,
  output logic [LINE_WORDS-1:0] o_mask
);

  logic [WORD_W-1:0]     r_mem [LINE_WORDS];
  logic [LINE_WORDS-1:0] r_mask;

  // Data slots carry no reset; the mask alone says which words are meaningful.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_idx] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_mask <= '0;
    end else if (i_clr) begin
      r_mask <= '0;
    end else if (i_wr_en) begin
      r_mask[i_wr_idx] <= 1'b1;
    end
  end

  assign o_rd_data = r_mem[i_rd_idx];
  assign o_mask    = r_mask;

endmodule

// File: rtl/refill_fwd.sv
// Critical-word forwarding for an I-cache line refill (FSM + miss matching).
// Define REFILL_FWD_BYPASS_EN for a zero-latency combinational forward path.
module refill_fwd
  import icache_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int WORD_W     = DEF_WORD_W,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int OFFS_W     = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fill_start,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic              beat_valid,
  input  logic [OFFS_W-1:0] beat_idx,
  input  logic [WORD_W-1:0] beat_data,
  input  logic              fill_done,
  input  logic              miss,
  input  logic [ADDR_W-1:0] miss_addr,
  output logic              fwd_valid,
  output logic [WORD_W-1:0] fwd_data,
  output logic              busy,
  output logic              line_valid
);

  localparam int TAG_W = ADDR_W - OFFS_W;

  fill_state_e           r_state;
  logic [TAG_W-1:0]      r_tag;
  logic                  r_pend_vld;
  logic [OFFS_W-1:0]     r_pend_off;
  logic                  r_line_valid;

  logic                  w_busy;
  logic                  w_beat;
  logic [OFFS_W-1:0]     w_miss_off;
  logic                  w_match;
  logic                  w_miss_beat;
  logic                  w_miss_avail;
  logic [WORD_W-1:0]     w_rd_data;
  logic [LINE_WORDS-1:0] w_mask;
  logic [LINE_WORDS-1:0] w_mask_next;
  logic                  w_pend_hit;
  logic                  w_miss_wait;
  logic                  w_fwd_vld;
  logic [WORD_W-1:0]     w_fwd_data;
  logic                  w_unused_offs;

  assign w_unused_offs = ^fill_addr[OFFS_W-1:0];

  refill_line_buf #(
    .WORD_W     (WORD_W),
    .LINE_WORDS (LINE_WORDS),
    .OFFS_W     (OFFS_W)
  ) u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_clr     (fill_start),
    .i_wr_en   (w_beat),
    .i_wr_idx  (beat_idx),
    .i_wr_data (beat_data),
    .i_rd_idx  (w_miss_off),
    .o_rd_data (w_rd_data),
    .o_mask    (w_mask)
  );

  // fill_start owns its cycle: beats and misses alongside it are discarded.
  assign w_busy       = (r_state != ST_IDLE);
  assign w_beat       = beat_valid && w_busy && !fill_start;
  assign w_miss_off   = miss_addr[OFFS_W-1:0];
  assign w_match      = miss && !fill_start && (miss_addr[ADDR_W-1:OFFS_W] == r_tag)
                        && (w_busy || r_line_valid);
  assign w_miss_beat  = w_beat && (beat_idx == w_miss_off);
  assign w_miss_avail = w_mask[w_miss_off] || w_miss_beat;
  assign w_miss_wait  = w_match && !w_miss_avail && w_busy;
  assign w_pend_hit   = r_pend_vld && !w_match && w_beat && (beat_idx == r_pend_off);
  assign w_mask_next  = w_mask | (w_beat ? (LINE_WORDS'(1) << beat_idx) : '0);

  // A same-cycle beat is the newest copy of the word, so it beats the buffer.
  always_comb begin
    w_fwd_vld  = (w_match && w_miss_avail) || w_pend_hit;
    w_fwd_data = '0;
    if (w_match && w_miss_avail) begin
      w_fwd_data = w_miss_beat ? beat_data : w_rd_data;
    end else if (w_pend_hit) begin
      w_fwd_data = beat_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_tag        <= '0;
      r_pend_vld   <= 1'b0;
      r_pend_off   <= '0;
      r_line_valid <= 1'b0;
    end else if (fill_start) begin
      r_state      <= ST_FILL;
      r_tag        <= fill_addr[ADDR_W-1:OFFS_W];
      r_pend_vld   <= 1'b0;
      r_line_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_FILL, ST_WAIT: begin
          if (fill_done) begin
            r_state      <= ST_IDLE;
            r_pend_vld   <= 1'b0;
            r_line_valid <= &w_mask_next;
          end else if (w_miss_wait) begin
            r_state    <= ST_WAIT;
            r_pend_vld <= 1'b1;
            r_pend_off <= w_miss_off;
          end else if (w_fwd_vld) begin
            r_state    <= ST_FILL;
            r_pend_vld <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef REFILL_FWD_BYPASS_EN
  assign fwd_valid = w_fwd_vld;
  assign fwd_data  = w_fwd_data;
`else
  logic              r_fwd_vld_p1;
  logic [WORD_W-1:0] r_fwd_data_p1;

  // Stage p1: registered forward, one cycle after the miss or awaited beat.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_fwd_vld_p1  <= 1'b0;
      r_fwd_data_p1 <= '0;
    end else begin
      r_fwd_vld_p1  <= w_fwd_vld;
      r_fwd_data_p1 <= w_fwd_data;
    end
  end

  assign fwd_valid = r_fwd_vld_p1;
  assign fwd_data  = r_fwd_data_p1;
`endif

  assign busy       = w_busy;
  assign line_valid = r_line_valid;

endmodule

// File: tb/tb_refill_fwd.sv
// Scoreboard bench for refill_fwd; works with or without REFILL_FWD_BYPASS_EN.
module tb_refill_fwd;
  import icache_pkg::*;

  localparam int ADDR_W = 18;
  localparam int WORD_W = 32;
  localparam int LINE_WORDS = 4;
  localparam int OFFS_W = 2;
`ifdef REFILL_FWD_BYPASS_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              fill_start = 1'b0;
  logic [ADDR_W-1:0] fill_addr = '0;
  logic              beat_valid = 1'b0;
  logic [OFFS_W-1:0] beat_idx = '0;
  logic [WORD_W-1:0] beat_data = '0;
  logic              fill_done = 1'b0;
  logic              miss = 1'b0;
  logic [ADDR_W-1:0] miss_addr = '0;
  logic              fwd_valid;
  logic [WORD_W-1:0] fwd_data;
  logic              busy;
  logic              line_valid;

  refill_fwd #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .LINE_WORDS(LINE_WORDS)) dut (
    .clk(clk), .reset_n(reset_n), .fill_start(fill_start), .fill_addr(fill_addr),
    .beat_valid(beat_valid), .beat_idx(beat_idx), .beat_data(beat_data),
    .fill_done(fill_done), .miss(miss), .miss_addr(miss_addr),
    .fwd_valid(fwd_valid), .fwd_data(fwd_data), .busy(busy), .line_valid(line_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [WORD_W-1:0] data; int due; } exp_t;
  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 1'b0;
  logic [WORD_W-1:0] d [LINE_WORDS];

  // Scoreboard monitor: every forward must match the head expectation on its due cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      n_tests++;
      if (fwd_valid === 1'b1) begin
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL fwd_unexpected: fwd_valid=1 data=%h at cycle %0d, required no forward", fwd_data, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (e.due !== cyc || fwd_data !== e.data) begin
            n_fail++;
            $display("FAIL fwd_word: got data=%h at cycle %0d, required data=%h at cycle %0d", fwd_data, cyc, e.data, e.due);
          end
        end
      end else begin
        if (fwd_data !== '0) begin
          n_fail++;
          $display("FAIL fwd_data_idle: fwd_data=%h with fwd_valid=%b, required 0", fwd_data, fwd_valid);
        end
        if (q.size() > 0 && q[0].due <= cyc) begin
          n_fail++;
          $display("FAIL fwd_missing: no forward at cycle %0d, required data=%h due cycle %0d", cyc, q[0].data, q[0].due);
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic cyc_in(input logic fs, input logic [ADDR_W-1:0] fa, input logic bv,
                        input logic [OFFS_W-1:0] bi, input logic [WORD_W-1:0] bd,
                        input logic fd, input logic m, input logic [ADDR_W-1:0] ma);
    fill_start = fs; fill_addr = fa; beat_valid = bv; beat_idx = bi; beat_data = bd;
    fill_done = fd; miss = m; miss_addr = ma;
    @(posedge clk); #1;
    fill_start = 0; beat_valid = 0; fill_done = 0; miss = 0;
  endtask

  task automatic start(input logic [ADDR_W-1:0] a); cyc_in(1, a, 0, 0, 0, 0, 0, 0); endtask
  task automatic beat(input int i, input logic fd); cyc_in(0, 0, 1, OFFS_W'(i), d[i], fd, 0, 0); endtask
  task automatic do_miss(input logic [ADDR_W-1:0] a); cyc_in(0, 0, 0, 0, 0, 0, 1, a); endtask
  task automatic idle(input int n); for (int k = 0; k < n; k++) cyc_in(0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic expect_fwd(input logic [WORD_W-1:0] v); q.push_back('{v, cyc + LAT}); endtask
  task automatic new_data(); for (int k = 0; k < LINE_WORDS; k++) d[k] = $urandom; endtask

  task automatic test_reset();
    reset_n = 0;
    idle(2);
    n_tests++;
    if (busy !== 0 || line_valid !== 0 || fwd_valid !== 0 || fwd_data !== 0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b line_valid=%b fwd_valid=%b fwd_data=%h, required all 0", busy, line_valid, fwd_valid, fwd_data);
    end
    reset_n = 1;
    idle(1);
    mon_en = 1;
  endtask

  task automatic test_miss_before_beat();
    new_data();
    start(18'h1000); beat(0, 0); beat(1, 0);
    do_miss(18'h1002);
    n_tests++;
    if (dut.r_state !== ST_WAIT || busy !== 1) begin
      n_fail++; $display("FAIL wait_entry: state=%0d busy=%b, required WAIT busy=1", dut.r_state, busy);
    end
    expect_fwd(d[2]); beat(2, 0);
    beat(3, 0);
    cyc_in(0, 0, 0, 0, 0, 1, 0, 0);
    n_tests++;
    if (line_valid !== 1 || busy !== 0) begin
      n_fail++; $display("FAIL fill_complete: line_valid=%b busy=%b, required 1 and 0", line_valid, busy);
    end
  endtask

  task automatic test_hit_valid();
    bit saw_wait = 0;
    new_data();
    start(18'h1000); beat(0, 0); beat(1, 0);
    expect_fwd(d[1]); do_miss(18'h1001);
    if (dut.r_state == ST_WAIT) saw_wait = 1;
    beat(2, 0);
    if (dut.r_state == ST_WAIT) saw_wait = 1;
    beat(3, 1);
    n_tests++;
    if (saw_wait || line_valid !== 1) begin
      n_fail++; $display("FAIL hit_no_wait: saw_wait=%b line_valid=%b, required 0 and 1", saw_wait, line_valid);
    end
    expect_fwd(d[3]); do_miss(18'h1003);
    do_miss(18'h1403);
    idle(1);
  endtask

  task automatic test_nomatch();
    new_data();
    start(18'h1000);
    do_miss(18'h2003);
    for (int k = 0; k < LINE_WORDS; k++) beat(k, k == LINE_WORDS - 1);
    do_miss(18'h2003);
    idle(2);
    n_tests++;
    if (busy !== 0 || line_valid !== 1) begin
      n_fail++; $display("FAIL nomatch_end: busy=%b line_valid=%b, required 0 and 1", busy, line_valid);
    end
  endtask

  task automatic test_same_cycle_and_overwrite();
    new_data();
    start(18'h1000);
    n_tests++;
    if (line_valid !== 0 || busy !== 1) begin
      n_fail++; $display("FAIL restart_clears: line_valid=%b busy=%b, required 0 and 1", line_valid, busy);
    end
    expect_fwd(d[0]); cyc_in(0, 0, 1, 0, d[0], 0, 1, 18'h1000);
    d[1] = 32'h1111_1111; beat(1, 0);
    d[1] = 32'h2222_2222; beat(1, 0);
    expect_fwd(32'h2222_2222); do_miss(18'h1001);
    cyc_in(0, 0, 0, 0, 0, 1, 0, 0);
    n_tests++;
    if (line_valid !== 0) begin
      n_fail++; $display("FAIL partial_line: line_valid=%b, required 0", line_valid);
    end
  endtask

  task automatic test_replace_pending();
    new_data();
    start(18'h1000); beat(0, 0);
    do_miss(18'h1002); do_miss(18'h1003);
    beat(2, 0);
    n_tests++;
    if (dut.r_state !== ST_WAIT) begin
      n_fail++; $display("FAIL replaced_wait: state=%0d, required WAIT", dut.r_state);
    end
    expect_fwd(d[3]); beat(3, 0);
    beat(1, 1);
    idle(1);
  endtask

  task automatic test_done_with_last();
    new_data();
    start(18'h1000); beat(0, 0); beat(1, 0); beat(2, 0);
    do_miss(18'h1003);
    expect_fwd(d[3]); beat(3, 1);
    n_tests++;
    if (line_valid !== 1 || busy !== 0 || dut.r_state !== ST_IDLE) begin
      n_fail++; $display("FAIL done_last: line_valid=%b busy=%b state=%0d, required 1 0 IDLE", line_valid, busy, dut.r_state);
    end
    idle(1);
  endtask

  task automatic test_done_drops_pending();
    new_data();
    start(18'h1000); beat(0, 0);
    do_miss(18'h1002);
    cyc_in(0, 0, 0, 0, 0, 1, 0, 0);
    n_tests++;
    if (line_valid !== 0 || busy !== 0) begin
      n_fail++; $display("FAIL done_drop: line_valid=%b busy=%b, required 0 and 0", line_valid, busy);
    end
    beat(2, 0);
    idle(2);
  endtask

  task automatic test_reset_mid();
    new_data();
    start(18'h1000); beat(0, 0); beat(1, 0);
    do_miss(18'h1002);
    reset_n = 0;
    idle(1);
    n_tests++;
    if (busy !== 0 || line_valid !== 0 || fwd_valid !== 0 || fwd_data !== 0 || dut.r_state !== ST_IDLE) begin
      n_fail++; $display("FAIL reset_mid: busy=%b line_valid=%b fwd_valid=%b fwd_data=%h state=%0d, required all 0", busy, line_valid, fwd_valid, fwd_data, dut.r_state);
    end
    reset_n = 1;
    beat(2, 0);
    do_miss(18'h0002);
    idle(2);
  endtask

  initial begin
    test_reset();
    test_miss_before_beat();
    test_hit_valid();
    test_nomatch();
    test_same_cycle_and_overwrite();
    test_replace_pending();
    test_done_with_last();
    test_done_drops_pending();
    test_reset_mid();
    idle(3);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: %0d forwards outstanding, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
